// File: rtl/rv32i_pkg.sv
// Shared RV32I types for the writeback path: register index, data word and a
// writeback request bundle.
package rv32i_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NREGS     = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        xlen_t    data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Outstanding-load scoreboard: one pending bit per architectural register
// (x0 never pending), busy lookups for both read ports, and a sticky error.
module wb_scoreboard
    import rv32i_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     issue_load_i,
    input  reg_idx_t issue_rd_i,
    input  logic     clr_i,
    input  reg_idx_t clr_rd_i,
    input  reg_idx_t rs1_i,
    input  reg_idx_t rs2_i,
    output logic     rs1_busy_o,
    output logic     rs2_busy_o,
    output logic     err_o
);

    localparam logic [NREGS-1:0] ONE_HOT_0 = {{(NREGS-1){1'b0}}, 1'b1};

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] set_mask_s;
    logic [NREGS-1:0] clr_mask_s;
    logic             set_en_s;
    logic             err_q;
    logic             err_d;

    // Next pending vector and error; the set mask is applied after the clear so a
    // back-to-back load to the same register keeps its bit.
    always_comb begin
        set_en_s   = issue_load_i && (issue_rd_i != 5'd0);
        set_mask_s = set_en_s ? (ONE_HOT_0 << issue_rd_i) : {NREGS{1'b0}};
        clr_mask_s = clr_i ? (ONE_HOT_0 << clr_rd_i) : {NREGS{1'b0}};
        pending_d  = ((pending_q & ~clr_mask_s) | set_mask_s) & ~ONE_HOT_0;
        err_d      = err_q
                   | (set_en_s && pending_q[issue_rd_i]
                      && !(clr_i && (clr_rd_i == issue_rd_i)));
    end

    // Scoreboard state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= {NREGS{1'b0}};
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign rs1_busy_o = pending_q[rs1_i];
    assign rs2_busy_o = pending_q[rs2_i];
    assign err_o      = err_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port: mem-first
// priority with an ALU anti-starvation override, registered write, forwarding.
module regfile_wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     alu_valid,
    input  reg_idx_t alu_rd,
    input  xlen_t    alu_data,
    output logic     alu_ready,
    input  logic     mem_valid,
    input  reg_idx_t mem_rd,
    input  xlen_t    mem_data,
    output logic     mem_ready,
    input  logic     issue_load,
    input  reg_idx_t issue_rd,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    input  xlen_t    reg1,
    input  xlen_t    reg2,
    output xlen_t    rs1_data,
    output xlen_t    rs2_data,
    output logic     rs1_busy,
    output logic     rs2_busy,
    output logic     wb_write,
    output reg_idx_t wb_rd,
    output xlen_t    wb_data,
    output logic     err
);

    localparam int unsigned    SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

    wb_req_t       alu_req_s;
    wb_req_t       mem_req_s;
    wb_req_t       win_req_s;
    logic          alu_pri_s;
    logic          alu_ready_s;
    logic          mem_ready_s;
    logic          alu_acc_s;
    logic          mem_acc_s;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          wb_write_q;
    logic          wb_write_d;
    reg_idx_t      wb_rd_q;
    reg_idx_t      wb_rd_d;
    xlen_t         wb_data_q;
    xlen_t         wb_data_d;

    assign alu_req_s = '{valid: alu_valid, rd: alu_rd, data: alu_data};
    assign mem_req_s = '{valid: mem_valid, rd: mem_rd, data: mem_data};

    // Grant: ALU when it has waited STARVE_LIMIT cycles, else mem, else ALU.
    always_comb begin
        alu_ready_s = 1'b0;
        mem_ready_s = 1'b0;
        alu_pri_s   = (starve_q == STARVE_MAX) && alu_req_s.valid;
        if (rst) begin
            alu_ready_s = 1'b0;
            mem_ready_s = 1'b0;
        end else if (alu_pri_s) begin
            alu_ready_s = 1'b1;
        end else if (mem_req_s.valid) begin
            mem_ready_s = 1'b1;
        end else if (alu_req_s.valid) begin
            alu_ready_s = 1'b1;
        end else begin
            alu_ready_s = 1'b0;
            mem_ready_s = 1'b0;
        end
    end

    assign alu_acc_s = alu_req_s.valid && alu_ready_s;
    assign mem_acc_s = mem_req_s.valid && mem_ready_s;

    // Winner selection, starve counter and writeback register next-state.
    always_comb begin
        win_req_s       = mem_acc_s ? mem_req_s : alu_req_s;
        win_req_s.valid = alu_acc_s || mem_acc_s;
        if (alu_req_s.valid && !alu_ready_s) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : (starve_q + SW'(1));
        end else begin
            starve_d = {SW{1'b0}};
        end
        wb_write_d = win_req_s.valid && (win_req_s.rd != 5'd0);
        wb_rd_d    = win_req_s.valid ? win_req_s.rd   : wb_rd_q;
        wb_data_d  = win_req_s.valid ? win_req_s.data : wb_data_q;
    end

    // Writeback output register and starve counter, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q   <= {SW{1'b0}};
            wb_write_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'h0000_0000;
        end else begin
            starve_q   <= starve_d;
            wb_write_q <= wb_write_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Bypass the write that the register file has not yet committed; x0 reads 0.
    always_comb begin
        if (rs1 == 5'd0) begin
            rs1_data = 32'h0000_0000;
        end else if (wb_write_q && (wb_rd_q == rs1)) begin
            rs1_data = wb_data_q;
        end else begin
            rs1_data = reg1;
        end
        if (rs2 == 5'd0) begin
            rs2_data = 32'h0000_0000;
        end else if (wb_write_q && (wb_rd_q == rs2)) begin
            rs2_data = wb_data_q;
        end else begin
            rs2_data = reg2;
        end
    end

    wb_scoreboard u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .issue_load_i (issue_load),
        .issue_rd_i   (issue_rd),
        .clr_i        (mem_acc_s),
        .clr_rd_i     (mem_rd),
        .rs1_i        (rs1),
        .rs2_i        (rs2),
        .rs1_busy_o   (rs1_busy),
        .rs2_busy_o   (rs2_busy),
        .err_o        (err)
    );

    assign alu_ready = alu_ready_s;
    assign mem_ready = mem_ready_s;
    assign wb_write  = wb_write_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, starvation, scoreboard,
// forwarding, x0 handling and reset mid-operation.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        issue_load;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        wb_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .issue_load (issue_load),
        .issue_rd   (issue_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .reg1       (reg1),
        .reg2       (reg2),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .wb_write   (wb_write),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0;
        mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h0;
        issue_load = 1'b0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        reg1 = 32'h0; reg2 = 32'h0;
        #1;
        check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        step();
        step();
        check("rst_wb_write", {31'd0, wb_write}, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;

        // Single ALU write with forwarding
        step();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEAD_BEEF;
        #1;
        check("alu1_ready", {31'd0, alu_ready}, 32'd1);
        check("alu1_mem_ready", {31'd0, mem_ready}, 32'd0);
        step();
        alu_valid = 1'b0; rs1 = 5'd3; reg1 = 32'h0;
        #1;
        check("alu1_wb_write", {31'd0, wb_write}, 32'd1);
        check("alu1_wb_rd", {27'd0, wb_rd}, 32'd3);
        check("alu1_wb_data", wb_data, 32'hDEAD_BEEF);
        check("alu1_fwd_rs1", rs1_data, 32'hDEAD_BEEF);
        step();
        check("idle_wb_write", {31'd0, wb_write}, 32'd0);
        check("idle_wb_rd_hold", {27'd0, wb_rd}, 32'd3);
        check("idle_no_fwd", rs1_data, 32'h0);

        // Contention: mem wins, ALU follows once mem drops
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
        #1;
        check("cont_mem_ready", {31'd0, mem_ready}, 32'd1);
        check("cont_alu_ready", {31'd0, alu_ready}, 32'd0);
        step();
        mem_valid = 1'b0;
        #1;
        check("cont_wb_rd", {27'd0, wb_rd}, 32'd2);
        check("cont_wb_data", wb_data, 32'h22);
        check("cont_alu_ready2", {31'd0, alu_ready}, 32'd1);
        step();
        alu_valid = 1'b0;
        #1;
        check("cont_wb_rd_alu", {27'd0, wb_rd}, 32'd1);
        check("cont_wb_data_alu", wb_data, 32'h11);
        step();

        // Starvation: ALU wins on the fifth contended cycle
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rd = 5'(10 + i); mem_data = 32'h100 + i;
            #1;
            check("starve_alu_blocked", {31'd0, alu_ready}, 32'd0);
            check("starve_mem_ready", {31'd0, mem_ready}, 32'd1);
            step();
        end
        mem_rd = 5'd14; mem_data = 32'h104;
        #1;
        check("starve_alu_wins", {31'd0, alu_ready}, 32'd1);
        check("starve_mem_held", {31'd0, mem_ready}, 32'd0);
        check("starve_prev_wb_rd", {27'd0, wb_rd}, 32'd13);
        step();
        #1;
        check("starve_wb_rd_alu", {27'd0, wb_rd}, 32'd9);
        check("starve_cnt_cleared", {31'd0, alu_ready}, 32'd0);
        check("starve_mem_again", {31'd0, mem_ready}, 32'd1);
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        step();

        // Scoreboard set / clear / back-to-back / error
        issue_load = 1'b1; issue_rd = 5'd5;
        step();
        issue_load = 1'b0; rs1 = 5'd5; rs2 = 5'd5; reg1 = 32'h0;
        #1;
        check("sb_busy_rs1", {31'd0, rs1_busy}, 32'd1);
        check("sb_busy_rs2", {31'd0, rs2_busy}, 32'd1);
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h55;
        #1;
        check("sb_mem_ready", {31'd0, mem_ready}, 32'd1);
        check("sb_busy_same_cycle", {31'd0, rs1_busy}, 32'd1);
        step();
        mem_valid = 1'b0;
        #1;
        check("sb_busy_cleared", {31'd0, rs1_busy}, 32'd0);
        check("sb_fwd_load", rs1_data, 32'h55);
        issue_load = 1'b1; issue_rd = 5'd5;
        step();
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h56;
        step();
        issue_load = 1'b0; mem_valid = 1'b0;
        #1;
        check("sb_b2b_no_err", {31'd0, err}, 32'd0);
        check("sb_b2b_busy", {31'd0, rs1_busy}, 32'd1);
        issue_load = 1'b1;
        step();
        issue_load = 1'b0;
        #1;
        check("sb_err_set", {31'd0, err}, 32'd1);
        check("sb_err_busy", {31'd0, rs1_busy}, 32'd1);
        step();
        check("sb_err_sticky", {31'd0, err}, 32'd1);

        // x0 handling
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
        #1;
        check("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
        step();
        alu_valid = 1'b0; rs1 = 5'd0; reg1 = 32'h1234;
        #1;
        check("x0_wb_write", {31'd0, wb_write}, 32'd0);
        check("x0_rs1_data", rs1_data, 32'h0);
        issue_load = 1'b1; issue_rd = 5'd0;
        step();
        issue_load = 1'b0;
        #1;
        check("x0_no_busy", {31'd0, rs1_busy}, 32'd0);

        // Reset mid-operation
        issue_load = 1'b1; issue_rd = 5'd7;
        step();
        issue_load = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        step();
        alu_valid = 1'b0; rs1 = 5'd7;
        #1;
        check("mid_pre_wb_write", {31'd0, wb_write}, 32'd1);
        check("mid_pre_busy", {31'd0, rs1_busy}, 32'd1);
        rst = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1; mem_rd = 5'd8;
        #1;
        check("mid_rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        check("mid_rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        step();
        rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; reg1 = 32'hABCD;
        #1;
        check("mid_wb_write", {31'd0, wb_write}, 32'd0);
        check("mid_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("mid_wb_data", wb_data, 32'd0);
        check("mid_busy", {31'd0, rs1_busy}, 32'd0);
        check("mid_err", {31'd0, err}, 32'd0);
        check("mid_rs1_data", rs1_data, 32'hABCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of `register_file` (`write`/`rd`/`reg_write`).
- Arbitrates between two writeback requesters, the ALU path and the load/memory path, using valid/ready handshakes.
- Tracks outstanding loads in a 32-entry pending scoreboard.
- Forwards the in-flight write onto the two read ports, so decode sees coherent operands and a busy indication.

Parameters:
- XLEN, 32, data width of register values
- NREGS, 32, architectural register count (index width = $clog2(NREGS) = 5)
- STARVE_LIMIT, 4, consecutive ALU-stall cycles after which the ALU gets priority for one grant

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load writeback request
- mem_rd  in  5  load destination register
- mem_data  in  32  load result
- mem_ready  out  1  load request accepted this cycle
- issue_load  in  1  a load is issued this cycle (marks rd pending)
- issue_rd  in  5  destination of the issued load
- rs1  in  5  read address 1 (also driven to register_file)
- rs2  in  5  read address 2
- reg1  in  32  register_file read data 1
- reg2  in  32  register_file read data 2
- rs1_data  out  32  forwarded operand 1
- rs2_data  out  32  forwarded operand 2
- rs1_busy  out  1  rs1 has an outstanding load
- rs2_busy  out  1  rs2 has an outstanding load
- wb_write  out  1  to register_file `write`
- wb_rd  out  5  to register_file `rd`
- wb_data  out  32  to register_file `reg_write`
- err  out  1  sticky: load issued to an already-pending register

Behaviour:
- **Reset.** When rst=1 at a posedge, the following clear to 0: wb_write, wb_rd, wb_data, the pending vector, the starve counter and err. alu_ready and mem_ready are 0 while rst=1.
- **Arbitration (combinational).**
  - Default priority is mem over ALU.
  - If starve_cnt == STARVE_LIMIT and alu_valid, the ALU wins instead.
  - At most one ready is asserted per cycle; ready is asserted only to the winning valid requester.
- **Acceptance.** A handshake completes when valid && ready. The winner's rd and data are registered into wb_rd/wb_data on the next edge.
  - wb_write is set to 1 only if the accepted rd != 0.
  - A write to x0 is accepted but dropped (wb_write=0).
  - With no acceptance, wb_write=0 next cycle; wb_rd and wb_data hold their values.
- **Latency.** Request to register_file write enable is 1 cycle. The register file commits on the following edge.
- **Starve counter.**
  - Increments (saturating at STARVE_LIMIT) on each cycle with alu_valid && !alu_ready.
  - Clears on ALU acceptance.
  - Clears on any cycle with alu_valid=0.
- **Scoreboard.** pending[NREGS] has bit 0 hardwired to 0.
  - Set: issue_load && issue_rd != 0 sets pending[issue_rd].
  - Clear: mem acceptance clears pending[mem_rd].
  - Same rd set and cleared in the same cycle: set wins (back-to-back load).
  - Error: issue to an already-pending rd with no same-cycle clear sets err sticky until rst. The pending bit stays 1.
- **Busy (combinational).** rsN_busy = pending[rsN].
  - The bit reads its registered value, so a same-cycle clear is not visible.
  - rsN == 0 gives busy=0.
- **Forwarding (combinational).**
  - If wb_write && wb_rd == rsN && rsN != 0, then rsN_data = wb_data; otherwise rsN_data = regN.
  - rsN == 0 always yields 0 regardless of regN.
- **Reset mid-operation.** Pending loads are discarded. Requesters must re-present after reset, and no ready is asserted during reset.

Decomposition:
- **Package `rv32i_pkg`:** XLEN, NREGS, REG_IDX_W=5, typedef reg_idx_t (logic [4:0]), typedef xlen_t (logic [31:0]), and a wb_req_t struct {valid, rd, data}.
- **Sub-module `wb_scoreboard`:** pending vector, set/clear/err logic, and the two busy lookups.
- Arbitration, starve counter, output register and forwarding stay in the top module.

Test Plan:
- **Single ALU write:** reset, then alu_valid=1, rd=3, data=0xDEADBEEF.
  - alu_ready=1 same cycle; next cycle wb_write=1, wb_rd=3, wb_data=0xDEADBEEF.
  - With rs1=3 that cycle, rs1_data=0xDEADBEEF even though reg1=0.
- **Contention:** alu rd=1/data=0x11 and mem rd=2/data=0x22 both valid in cycle 0.
  - mem_ready=1, alu_ready=0 in cycle 0; wb shows rd=2, 0x22 in cycle 1.
  - ALU is accepted when mem drops valid.
- **Starvation:** mem_valid held high continuously (distinct rds), alu_valid held high.
  - alu_ready=0 for 4 cycles, then alu_ready=1 in cycle 4 with mem_ready=0.
  - Counter back to 0 afterwards.
- **Scoreboard:** issue_load rd=5 → rs1=5 gives rs1_busy=1 next cycle.
  - mem writes rd=5 (accepted) → busy=0 the cycle after.
  - issue rd=5 twice without a write → err=1 sticky.
- **x0 handling:** alu rd=0, data=0xFFFFFFFF accepted → wb_write=0; rs1=0 gives rs1_data=0 with reg1 forced to 0x1234; issue_load rd=0 gives no busy.
- **Reset mid-operation:** pending[7]=1 and wb_write=1, then rst=1 for one edge → all outputs 0, rs1_busy=0 for rs1=7, err=0, ready=0 during rst.
